muldiv_seq: RTL

Iterative multiply/divide sequencer with dedicated HI/LO registers, sitting beside the ALU in the execute stage. The control unit issues MULT, MULTU, DIV, DIVU, MTHI and MTLO through a start/op handshake. The block then runs a fixed-latency shift-add or restoring-divide sequence and writes HI/LO. It raises `busy` so the control unit can stall MFHI/MFLO and further muldiv issues until `done`.

---
 rtl/muldiv_seq_if.sv | 16 +
 rtl/muldiv_seq.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq_if.sv
// Issue/result bundle between the control unit and the multiply/divide sequencer.
interface muldiv_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, input busy, done, hi, lo);
  modport slave  (input start, op, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer with HI/LO registers and MTHI/MTLO moves.
module muldiv_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  muldiv_seq_if.slave  bus
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;
  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } op_t;

  state_t             r_state, w_state_nxt;
  logic [2*WIDTH-1:0] r_acc, w_acc_nxt;
  logic [WIDTH-1:0]   r_opnd, w_opnd_nxt;
  logic [CW-1:0]      r_cnt, w_cnt_nxt;
  logic               r_neg_q, w_neg_q_nxt;
  logic               r_neg_r, w_neg_r_nxt;
  logic               r_is_div, w_is_div_nxt;
  logic [WIDTH-1:0]   r_hi, w_hi_nxt;
  logic [WIDTH-1:0]   r_lo, w_lo_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_done, w_done_nxt;

  logic               w_signed;
  logic [WIDTH-1:0]   w_mag_a, w_mag_b;
  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_trial;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quot, w_rem;

  assign w_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
  assign w_mag_a  = (w_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign w_mag_b  = (w_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;

  // MUL: acc = {partial product, remaining multiplier bits}, shifted right each step.
  assign w_addend = r_acc[0] ? r_opnd : '0;
  assign w_sum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};

  // DIV: acc = {remainder, dividend/quotient}; trial uses the remainder after the left shift.
  assign w_trial  = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_opnd};

  assign w_prod   = r_neg_q ? -r_acc : r_acc;
  assign w_quot   = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem    = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  always_comb begin
    w_state_nxt  = r_state;
    w_acc_nxt    = r_acc;
    w_opnd_nxt   = r_opnd;
    w_cnt_nxt    = r_cnt;
    w_neg_q_nxt  = r_neg_q;
    w_neg_r_nxt  = r_neg_r;
    w_is_div_nxt = r_is_div;
    w_hi_nxt     = r_hi;
    w_lo_nxt     = r_lo;
    w_done_nxt   = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (bus.start && !r_busy) begin
          case (bus.op)
            OP_MTHI: w_hi_nxt = bus.a;
            OP_MTLO: w_lo_nxt = bus.a;
            OP_MULT, OP_MULTU: begin
              w_state_nxt  = S_MUL;
              w_acc_nxt    = {{WIDTH{1'b0}}, w_mag_b};
              w_opnd_nxt   = w_mag_a;
              w_cnt_nxt    = '0;
              w_neg_q_nxt  = w_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
              w_neg_r_nxt  = 1'b0;
              w_is_div_nxt = 1'b0;
            end
            OP_DIV, OP_DIVU: begin
              w_state_nxt  = S_DIV;
              w_acc_nxt    = {{WIDTH{1'b0}}, w_mag_a};
              w_opnd_nxt   = w_mag_b;
              w_cnt_nxt    = '0;
              // Divide by zero keeps the all-ones quotient; remainder negation restores a.
              w_neg_q_nxt  = w_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]) && (bus.b != '0);
              w_neg_r_nxt  = w_signed && bus.a[WIDTH-1];
              w_is_div_nxt = 1'b1;
            end
            default: ;
          endcase
        end
      end
      S_MUL: begin
        w_acc_nxt = {w_sum, r_acc[WIDTH-1:1]};
        w_cnt_nxt = r_cnt + CW'(1);
        if (r_cnt == CW'(WIDTH-1)) w_state_nxt = S_FIX;
      end
      S_DIV: begin
        if (!w_trial[WIDTH])
          w_acc_nxt = {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
        else
          w_acc_nxt = {r_acc[2*WIDTH-2:0], 1'b0};
        w_cnt_nxt = r_cnt + CW'(1);
        if (r_cnt == CW'(WIDTH-1)) w_state_nxt = S_FIX;
      end
      S_FIX: begin
        if (r_is_div) begin
          w_lo_nxt = w_quot;
          w_hi_nxt = w_rem;
        end else begin
          w_hi_nxt = w_prod[2*WIDTH-1:WIDTH];
          w_lo_nxt = w_prod[WIDTH-1:0];
        end
        w_done_nxt  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Busy stays up through the done cycle so a start there is still rejected.
    w_busy_nxt = (w_state_nxt != S_IDLE) || (r_state == S_FIX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_cnt    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_is_div <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_acc    <= w_acc_nxt;
      r_opnd   <= w_opnd_nxt;
      r_cnt    <= w_cnt_nxt;
      r_neg_q  <= w_neg_q_nxt;
      r_neg_r  <= w_neg_r_nxt;
      r_is_div <= w_is_div_nxt;
      r_hi     <= w_hi_nxt;
      r_lo     <= w_lo_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

endmodule
